// File: rtl/ifu_pkg.sv
// Shared types and constants for the instruction fetch unit.
//   INST_W / PC_W : instruction word and byte-address widths
//   ifu_entry_t   : prefetch buffer entry {code, pc}
//   ifu_state_t   : fetch FSM encoding (BOOT, RUN)
package ifu_pkg;

    localparam int unsigned INST_W = 32;
    localparam int unsigned PC_W   = 32;

    typedef struct packed {
        logic [INST_W-1:0] code;
        logic [PC_W-1:0]   pc;
    } ifu_entry_t;

    typedef enum logic {
        IFU_BOOT = 1'b0,
        IFU_RUN  = 1'b1
    } ifu_state_t;

    // Clear the byte-offset bits of a byte address.
    function automatic logic [PC_W-1:0] word_align(input logic [PC_W-1:0] pc);
        return pc & ~PC_W'(3);
    endfunction

endpackage

// File: rtl/ifu_fifo.sv
// Prefetch buffer: synchronous FIFO of DEPTH ifu_entry_t entries.
// Ports:
//   clka, rsta      : clock, asynchronous active-low reset
//   push, push_data : write one entry (caller never pushes when full)
//   pop             : retire head entry (caller never pops when empty)
//   flush           : empty the FIFO; dominates push and pop
//   head            : entry at the read pointer
//   count           : number of valid entries, 0..DEPTH
module ifu_fifo
    import ifu_pkg::*;
#(
    parameter int unsigned  DEPTH = 4,
    localparam int unsigned PTR_W = $clog2(DEPTH),
    localparam int unsigned CNT_W = PTR_W + 1
) (
    input  logic             clka,
    input  logic             rsta,
    input  logic             push,
    input  ifu_entry_t       push_data,
    input  logic             pop,
    input  logic             flush,
    output ifu_entry_t       head,
    output logic [CNT_W-1:0] count
);

    ifu_entry_t       mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;

    // Pointers wrap naturally because DEPTH is a power of two.
    always_ff @(posedge clka or negedge rsta) begin
        if (!rsta) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + PTR_W'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
            case ({push, pop})
                2'b10:   count <= count + CNT_W'(1);
                2'b01:   count <= count - CNT_W'(1);
                default: count <= count;
            endcase
        end
    end

    // Storage needs no reset; the owner qualifies head with count.
    always_ff @(posedge clka) begin
        if (push && !flush) begin
            mem[wr_ptr] <= push_data;
        end
    end

    assign head = mem[rd_ptr];

endmodule

// File: rtl/inst_fetch_unit.sv
// Instruction fetch unit: issues word reads to a synchronous ROM, buffers
// the returned words with their PCs in a DEPTH-entry prefetch FIFO and
// presents the head to decode. Redirects flush everything and restart.
// Ports:
//   clka, rsta           : clock, asynchronous active-low reset
//   rom_en, rom_addr     : ROM read request and word address
//   rom_data             : ROM read data, one cycle after rom_en
//   redir_valid/redir_pc : redirect request and byte target
//   inst_valid/ready     : head instruction handshake
//   inst_code/pc/pc4     : head word, its byte address, and address + 4
//   fetch_cnt, flush_cnt : saturating issue/redirect counters, only when
//                          the IFU_STATS_EN macro is defined
module inst_fetch_unit
    import ifu_pkg::*;
#(
    parameter int unsigned     DEPTH    = 4,
    parameter int unsigned     ADDR_W   = 6,
    parameter logic [PC_W-1:0] RESET_PC = 32'h0
) (
    input  logic              clka,
    input  logic              rsta,
    output logic              rom_en,
    output logic [ADDR_W-1:0] rom_addr,
    input  logic [INST_W-1:0] rom_data,
    input  logic              redir_valid,
    input  logic [PC_W-1:0]   redir_pc,
    output logic              inst_valid,
    input  logic              inst_ready,
    output logic [INST_W-1:0] inst_code,
    output logic [PC_W-1:0]   inst_pc,
    output logic [PC_W-1:0]   inst_pc4
`ifdef IFU_STATS_EN
    ,
    output logic [15:0]       fetch_cnt,
    output logic [15:0]       flush_cnt
`endif
);

    localparam int unsigned CNT_W = $clog2(DEPTH) + 1;
    localparam int unsigned OCC_W = CNT_W + 1;

    ifu_state_t       state;
    logic [PC_W-1:0]  fetch_pc;
    logic [PC_W-1:0]  inflight_pc;
    logic             inflight;
    logic [CNT_W-1:0] count;
    logic [OCC_W-1:0] occupancy;
    logic             issue;
    logic             push;
    logic             pop;
    ifu_entry_t       push_entry;
    ifu_entry_t       head;

    // Reserve a slot for the outstanding read; a pop this cycle is not credited.
    assign occupancy = OCC_W'(count) + OCC_W'(inflight);
    assign issue     = (state == IFU_RUN) && !redir_valid && (occupancy < OCC_W'(DEPTH));

    // A redirect kills the response arriving this cycle and overrides any pop.
    assign push       = inflight && !redir_valid;
    assign pop        = inst_valid && inst_ready && !redir_valid;
    assign push_entry = {rom_data, inflight_pc};

    assign rom_en   = issue;
    assign rom_addr = fetch_pc[ADDR_W+1:2];

    // Fetch FSM and PC / inflight tracking.
    always_ff @(posedge clka or negedge rsta) begin
        if (!rsta) begin
            state       <= IFU_BOOT;
            fetch_pc    <= word_align(RESET_PC);
            inflight    <= 1'b0;
            inflight_pc <= '0;
        end else begin
            case (state)
                IFU_BOOT: state <= IFU_RUN;
                IFU_RUN:  state <= IFU_RUN;
                default:  state <= IFU_BOOT;
            endcase
            if (redir_valid) begin
                fetch_pc <= word_align(redir_pc);
            end else if (issue) begin
                fetch_pc <= fetch_pc + PC_W'(4);
            end
            inflight <= issue;
            if (issue) begin
                inflight_pc <= fetch_pc;
            end
        end
    end

    ifu_fifo #(
        .DEPTH (DEPTH)
    ) u_fifo (
        .clka      (clka),
        .rsta      (rsta),
        .push      (push),
        .push_data (push_entry),
        .pop       (pop),
        .flush     (redir_valid),
        .head      (head),
        .count     (count)
    );

    // Head fields read as zero whenever the buffer is empty.
    assign inst_valid = (count != '0);
    assign inst_code  = inst_valid ? head.code : '0;
    assign inst_pc    = inst_valid ? head.pc : '0;
    assign inst_pc4   = inst_valid ? (head.pc + PC_W'(4)) : '0;

`ifdef IFU_STATS_EN
    // Saturating issue and redirect counters.
    always_ff @(posedge clka or negedge rsta) begin
        if (!rsta) begin
            fetch_cnt <= '0;
            flush_cnt <= '0;
        end else begin
            if (issue && (fetch_cnt != 16'hFFFF)) begin
                fetch_cnt <= fetch_cnt + 16'd1;
            end
            if (redir_valid && (flush_cnt != 16'hFFFF)) begin
                flush_cnt <= flush_cnt + 16'd1;
            end
        end
    end
`endif

endmodule
